// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Keeps the program counter and issues one
// word-aligned request at a time to instruction memory. Fetched words go to
// decode through a registered output stage, backed by a one-entry skid
// buffer so that decode can stall without losing an in-flight response.
// A redirect from the branch unit reloads the PC and flushes wrong-path work.
// If the redirect arrives while a request is still waiting for its ack, the
// request is held stable and its data is dropped when it arrives.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_br_en      redirect request (taken branch / jump)
//   i_br_addr    redirect target, bits [1:0] ignored
//   i_stall      decode cannot accept; output register holds
//   o_imem_req   memory request valid
//   o_imem_addr  word-aligned request address
//   i_imem_ack   request accepted, i_imem_dat valid in the same cycle
//   i_imem_dat   instruction word returned by memory
//   o_inst       instruction presented to decode
//   o_pc         PC of o_inst
//   o_valid      o_inst/o_pc hold a correct-path instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_br_en,
    input  logic [31:0] i_br_addr,
    input  logic        i_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_dat,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DROP  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        out_vld_q, out_vld_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;

    logic [31:0] br_tgt;
    logic [31:0] reset_pc;
    logic        req;
    logic        ack_fire;
    logic        take;
    logic        unused_br_lsbs;

    assign br_tgt         = {i_br_addr[31:2], 2'b00};
    assign reset_pc       = {RESET_VECTOR[31:2], 2'b00};
    assign unused_br_lsbs = ^i_br_addr[1:0];

    // A request is outstanding every cycle out of reset unless the skid
    // buffer is holding a word; the buffer must drain before fetch resumes.
    // The buffer is always empty in DROP, since entering DROP flushes it.
    assign req      = ~i_rst & ~skid_vld_q;
    assign ack_fire = req & i_imem_ack;

    // An ack that is kept: normal fetch and no redirect in the same cycle.
    assign take     = ack_fire & (state_q == ST_FETCH) & ~i_br_en;

    assign o_imem_req  = req;
    // In DROP the PC already holds the redirect target, so the abandoned
    // request address is replayed from its own register until it is acked.
    assign o_imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

    assign o_inst  = out_inst_q;
    assign o_pc    = out_pc_q;
    assign o_valid = out_vld_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        skid_vld_d  = skid_vld_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        out_vld_d   = out_vld_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;

        if (i_br_en) begin
            // Redirect wins over stall: flush everything younger than the
            // branch and restart at the target.
            pc_d       = br_tgt;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (req && !i_imem_ack) begin
                        state_d     = ST_DROP;
                        drop_addr_d = pc_q;
                    end
                end
                ST_DROP: begin
                    // A newer target simply replaces the saved one; the
                    // pending request is still dropped on its ack.
                    if (ack_fire) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (take) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                ST_DROP: begin
                    if (ack_fire) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase

            if (!i_stall) begin
                if (skid_vld_q) begin
                    // No request is issued while the buffer is full, so
                    // there is never a competing ack in this cycle.
                    out_vld_d  = 1'b1;
                    out_inst_d = skid_inst_q;
                    out_pc_d   = skid_pc_q;
                    skid_vld_d = 1'b0;
                end else if (take) begin
                    out_vld_d  = 1'b1;
                    out_inst_d = i_imem_dat;
                    out_pc_d   = pc_q;
                end else begin
                    out_vld_d  = 1'b0;
                end
            end else if (take) begin
                skid_vld_d  = 1'b1;
                skid_inst_d = i_imem_dat;
                skid_pc_d   = pc_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= reset_pc;
            skid_vld_q <= 1'b0;
            out_vld_q  <= 1'b0;
            out_inst_q <= NOP_INST;
            out_pc_q   <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            skid_vld_q <= skid_vld_d;
            out_vld_q  <= out_vld_d;
            out_inst_q <= out_inst_d;
            out_pc_q   <= out_pc_d;
        end
    end

    // Payload registers are qualified by their valid/state bits.
    always_ff @(posedge i_clk) begin
        drop_addr_q <= drop_addr_d;
        skid_inst_q <= skid_inst_d;
        skid_pc_q   <= skid_pc_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The memory model answers combinationally
// with a word derived from the request address; the ack line is driven per
// cycle by the stimulus. Every instruction the bench expects decode to
// consume is queued by the stimulus; a monitor pops the queue on each
// consumed output (o_valid=1 and i_stall=0) and checks PC and data.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_en;
    logic [31:0] br_addr;
    logic        stall;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign dat = mem_word(addr);

    fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_br_en     (br_en),
        .i_br_addr   (br_addr),
        .i_stall     (stall),
        .o_imem_req  (req),
        .o_imem_addr (addr),
        .i_imem_ack  (ack),
        .i_imem_dat  (dat),
        .o_inst      (inst),
        .o_pc        (pc),
        .o_valid     (valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, apply inputs, then wait
    // for the falling edge where outputs are sampled.
    task automatic drive(input logic r, input logic b, input logic [31:0] ba,
                         input logic s, input logic a);
        @(posedge clk);
        #1;
        rst = r; br_en = b; br_addr = ba; stall = s; ack = a;
        @(negedge clk);
    endtask

    // Scoreboard monitor: one pop per instruction consumed by decode.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (!rst && valid && !stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: actual pc %h, required no output", pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", pc, e);
                chk("out_inst", inst, mem_word(e));
            end
        end
    end

    initial begin
        rst = 1'b1; br_en = 1'b0; br_addr = 32'h0; stall = 1'b0; ack = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        drive(1, 0, 32'h0, 0, 0);
        chk("rst_req2", 32'(req), 32'd0);

        // Streaming with ack tied high.
        drive(0, 0, 32'h0, 0, 1);                      // C0
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_pc", pc, 32'h0);
        chk("c0_req", 32'(req), 32'd1);
        chk("c0_addr", addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        drive(0, 0, 32'h0, 0, 1);                      // C1
        chk("c1_addr", addr, 32'h4);
        drive(0, 0, 32'h0, 0, 1);                      // C2
        chk("c2_addr", addr, 32'h8);

        // Stall three cycles while o_pc=8; addr 12 lands in the skid buffer.
        drive(0, 0, 32'h0, 1, 1);                      // C3
        chk("c3_addr", addr, 32'hC);
        chk("c3_pc", pc, 32'h8);
        drive(0, 0, 32'h0, 1, 1);                      // C4
        chk("c4_req_full", 32'(req), 32'd0);
        chk("c4_pc_hold", pc, 32'h8);
        chk("c4_valid_hold", 32'(valid), 32'd1);
        drive(0, 0, 32'h0, 1, 1);                      // C5
        chk("c5_req_full", 32'(req), 32'd0);
        chk("c5_inst_hold", inst, mem_word(32'h8));
        drive(0, 0, 32'h0, 0, 1);                      // C6 drain
        chk("c6_req_drain", 32'(req), 32'd0);
        drive(0, 0, 32'h0, 0, 1);                      // C7
        chk("c7_pc_skid", pc, 32'hC);
        chk("c7_addr", addr, 32'h10);

        // Redirect to 0x102 with ack in the same cycle.
        drive(0, 1, 32'h0000_0102, 0, 1);              // C8
        chk("c8_addr", addr, 32'h14);
        drive(0, 0, 32'h0, 0, 1);                      // C9
        chk("br_valid0", 32'(valid), 32'd0);
        chk("br_addr_tgt", addr, 32'h100);
        exp_q.push_back(32'h100);
        // Redirect to 0x20 on the cycle the first target word is shown.
        drive(0, 1, 32'h0000_0020, 0, 1);              // C10
        chk("br_lat_valid", 32'(valid), 32'd1);

        // 0x20 is acked only after four wait cycles; redirected meanwhile.
        drive(0, 0, 32'h0, 0, 0);                      // C11
        chk("c11_valid", 32'(valid), 32'd0);
        chk("c11_addr", addr, 32'h20);
        drive(0, 1, 32'h0000_0070, 0, 0);              // C12
        chk("c12_addr", addr, 32'h20);
        drive(0, 1, 32'h0000_0080, 0, 0);              // C13 overwrite target
        chk("drop_req", 32'(req), 32'd1);
        chk("drop_addr_hold", addr, 32'h20);
        drive(0, 0, 32'h0, 0, 0);                      // C14
        chk("c14_addr", addr, 32'h20);
        drive(0, 0, 32'h0, 0, 1);                      // C15 ack, dropped
        chk("c15_addr", addr, 32'h20);
        drive(0, 0, 32'h0, 0, 1);                      // C16
        chk("drop_valid0", 32'(valid), 32'd0);
        chk("drop_next_addr", addr, 32'h80);
        exp_q.push_back(32'h80);
        drive(0, 0, 32'h0, 0, 1);                      // C17
        chk("c17_addr", addr, 32'h84);

        // Fill the skid buffer, then redirect while stalled.
        drive(0, 0, 32'h0, 1, 1);                      // C18
        chk("c18_addr", addr, 32'h88);
        drive(0, 1, 32'h0000_0200, 1, 1);              // C19
        chk("c19_req_full", 32'(req), 32'd0);
        chk("c19_pc_hold", pc, 32'h84);
        drive(0, 0, 32'h0, 0, 1);                      // C20
        chk("flush_valid0", 32'(valid), 32'd0);
        chk("flush_req", 32'(req), 32'd1);
        chk("flush_addr", addr, 32'h200);
        exp_q.push_back(32'h200);

        // PC wrap at the top of the address space.
        drive(0, 1, 32'hFFFF_FFFE, 0, 1);              // C21
        drive(0, 0, 32'h0, 0, 1);                      // C22
        chk("wrap_tgt_addr", addr, 32'hFFFF_FFFC);
        drive(0, 0, 32'h0, 1, 0);                      // C23 waiting, stalled
        chk("wrap_addr", addr, 32'h0);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_valid", 32'(valid), 32'd1);

        // Reset in the middle of an outstanding request.
        drive(1, 0, 32'h0, 1, 0);                      // C24
        chk("mid_rst_req", 32'(req), 32'd0);
        drive(0, 0, 32'h0, 0, 1);                      // C25
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_inst", inst, 32'h0000_0013);
        chk("mid_rst_addr", addr, 32'h0);
        chk("mid_rst_req1", 32'(req), 32'd1);
        exp_q.push_back(32'h0);
        drive(0, 0, 32'h0, 0, 0);                      // C26
        chk("c26_addr", addr, 32'h4);
        drive(0, 0, 32'h0, 0, 0);                      // C27
        chk("end_valid", 32'(valid), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
